// File: rtl/shift_cnt_pkg.sv
// Shared constants and combinational helpers for the multimode shift counter:
// legality test and sequence-index decode for Johnson and one-hot ring codes.
package shift_cnt_pkg;

  localparam int MODE_JOHNSON = 0;
  localparam int MODE_RING    = 1;

  // Code lives in the low `width` bits of q; the rest is ignored.
  function automatic bit is_legal(input logic [31:0] q, input int width, input int mode);
    logic [32:0] m, v, inv;
    m   = (33'd1 << width) - 33'd1;
    v   = {1'b0, q} & m;
    inv = ~v & m;
    if (mode == MODE_RING) return (v != 33'd0) && ((v & (v - 33'd1)) == 33'd0);
    // Johnson codes are a run of ones anchored at bit 0 (0*1*) or at the MSB (1*0*).
    return (((v + 33'd1) & v) == 33'd0) || (((inv + 33'd1) & inv) == 33'd0);
  endfunction

  function automatic int phase_of(input logic [31:0] q, input int width, input int mode);
    int pc, pos;
    pc  = 0;
    pos = 0;
    for (int i = 0; i < 32; i++) begin
      if (i < width && q[i]) begin
        pc  = pc + 1;
        pos = i;
      end
    end
    if (mode == MODE_RING) return pos;
    if (q[0]) return pc;
    return (pc == 0) ? 0 : 2 * width - pc;
  endfunction

endpackage

// File: rtl/shift_cnt_phase_dec.sv
// Combinational decode of a counter code into its sequence index and a legality flag.
module shift_cnt_phase_dec
  import shift_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_JOHNSON,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] i_q,
  output logic [PW-1:0]    o_phase,
  output logic             o_legal
);

  assign o_phase = PW'(phase_of(32'(i_q), WIDTH, MODE));
  assign o_legal = is_legal(32'(i_q), WIDTH, MODE);

endmodule

// File: rtl/multimode_shift_counter.sv
// WIDTH-bit Johnson / one-hot ring counter with load, direction, phase index and wrap pulse.
// Define SHIFT_CNT_SELF_CORRECT_EN to add the illegal-state checker and the err output.
module multimode_shift_counter
  import shift_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_JOHNSON,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [PW-1:0]    phase,
  output logic             wrap
`ifdef SHIFT_CNT_SELF_CORRECT_EN
  ,
  output logic             err
`endif
);

  localparam logic [WIDTH-1:0] RST_Q = (MODE == MODE_RING) ? WIDTH'(1) : '0;
  localparam logic [PW-1:0]    LAST  = PW'((MODE == MODE_RING) ? WIDTH - 1 : 2 * WIDTH - 1);

  logic [WIDTH-1:0] r_q, w_step_q;
  logic [PW-1:0]    r_phase, w_step_phase, w_ld_phase;
  logic             r_wrap, w_step_wrap, w_fix, w_unused_ld_legal;

  shift_cnt_phase_dec #(.WIDTH(WIDTH), .MODE(MODE), .PW(PW)) u_ld_dec (
    .i_q     (load_val),
    .o_phase (w_ld_phase),
    .o_legal (w_unused_ld_legal)
  );

  always_comb begin
    w_step_q     = r_q;
    w_step_phase = r_phase;
    w_step_wrap  = 1'b0;
    if (!dir) begin
      if (MODE == MODE_RING) w_step_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      else                   w_step_q = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
      w_step_wrap  = (r_phase == LAST);
      w_step_phase = w_step_wrap ? '0 : r_phase + PW'(1);
    end else begin
      if (MODE == MODE_RING) w_step_q = {r_q[0], r_q[WIDTH-1:1]};
      else                   w_step_q = {~r_q[0], r_q[WIDTH-1:1]};
      w_step_wrap  = (r_phase == '0);
      w_step_phase = w_step_wrap ? LAST : r_phase - PW'(1);
    end
  end

`ifdef SHIFT_CNT_SELF_CORRECT_EN
  logic          w_q_legal, r_err;
  logic [PW-1:0] w_unused_q_phase;

  shift_cnt_phase_dec #(.WIDTH(WIDTH), .MODE(MODE), .PW(PW)) u_chk_dec (
    .i_q     (r_q),
    .o_phase (w_unused_q_phase),
    .o_legal (w_q_legal)
  );

  assign w_fix = ~w_q_legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_err <= 1'b0;
    else        r_err <= w_fix;
  end

  assign err = r_err;
`else
  assign w_fix = 1'b0;
`endif

  // Recovery from an illegal code outranks load and enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q     <= RST_Q;
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (w_fix) begin
      r_q     <= RST_Q;
      r_phase <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_q     <= load_val;
      r_phase <= w_ld_phase;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_q     <= w_step_q;
      r_phase <= w_step_phase;
      r_wrap  <= w_step_wrap;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign q     = r_q;
  assign phase = r_phase;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_multimode_shift_counter.sv
// Scoreboarded bench: Johnson W=4 (DUT a) and ring W=5 (DUT b) share clock and reset.
module tb_multimode_shift_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en_a = 0, dir_a = 0, load_a = 0;
  logic [3:0] lv_a = '0, q_a;
  logic [2:0] ph_a;
  logic       wrap_a;
  logic       en_b = 0, dir_b = 0, load_b = 0;
  logic [4:0] lv_b = '0, q_b;
  logic [3:0] ph_b;
  logic       wrap_b;
`ifdef SHIFT_CNT_SELF_CORRECT_EN
  logic       err_a, err_b;
`endif

  always #5 clk = ~clk;

  multimode_shift_counter #(.WIDTH(4), .MODE(0)) dut_a (
    .clk(clk), .reset(reset), .en(en_a), .dir(dir_a), .load(load_a), .load_val(lv_a),
    .q(q_a), .phase(ph_a), .wrap(wrap_a)
`ifdef SHIFT_CNT_SELF_CORRECT_EN
    , .err(err_a)
`endif
  );

  multimode_shift_counter #(.WIDTH(5), .MODE(1)) dut_b (
    .clk(clk), .reset(reset), .en(en_b), .dir(dir_b), .load(load_b), .load_val(lv_b),
    .q(q_b), .phase(ph_b), .wrap(wrap_b)
`ifdef SHIFT_CNT_SELF_CORRECT_EN
    , .err(err_b)
`endif
  );

  typedef struct {
    int          u;
    logic [31:0] q;
    int          ph;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   m_ph[2] = '{0, 0};

  // Code for a given sequence index, built from the index rather than by shifting.
  function automatic logic [31:0] mq(input int u, input int ph);
    if (u == 1) return 32'(1) << ph;
    if (ph <= 4) return (32'(1) << ph) - 32'd1;
    return 32'hF & ~((32'(1) << (ph - 4)) - 32'd1);
  endfunction

  task automatic cyc(input int u, input bit e, input bit d, input bit l, input logic [31:0] lv);
    int   last;
    exp_t x, y;
    logic [31:0] aq;
    int   aph;
    logic aw;
    last   = (u == 0) ? 7 : 4;
    x.u    = u;
    x.wrap = 1'b0;
    if (l) begin
      for (int p = 0; p <= last; p++) if (mq(u, p) == lv) m_ph[u] = p;
    end else if (e) begin
      if (!d) begin
        x.wrap  = (m_ph[u] == last);
        m_ph[u] = (m_ph[u] == last) ? 0 : m_ph[u] + 1;
      end else begin
        x.wrap  = (m_ph[u] == 0);
        m_ph[u] = (m_ph[u] == 0) ? last : m_ph[u] - 1;
      end
    end
    x.q  = mq(u, m_ph[u]);
    x.ph = m_ph[u];
    sb.push_back(x);
    if (u == 0) begin
      en_a = e; dir_a = d; load_a = l; lv_a = lv[3:0];
      en_b = 0; load_b = 0;
    end else begin
      en_b = e; dir_b = d; load_b = l; lv_b = lv[4:0];
      en_a = 0; load_a = 0;
    end
    @(posedge clk);
    #1;
    y   = sb.pop_front();
    aq  = (y.u == 0) ? 32'(q_a) : 32'(q_b);
    aph = (y.u == 0) ? int'(ph_a) : int'(ph_b);
    aw  = (y.u == 0) ? wrap_a : wrap_b;
    checks += 3;
    if (aq !== y.q) begin
      errors++; $display("FAIL q[%0d] got %h want %h", y.u, aq, y.q);
    end
    if (aph != y.ph) begin
      errors++; $display("FAIL phase[%0d] got %0d want %0d", y.u, aph, y.ph);
    end
    if (aw !== y.wrap) begin
      errors++; $display("FAIL wrap[%0d] got %b want %b", y.u, aw, y.wrap);
    end
    en_a = 0; load_a = 0; en_b = 0; load_b = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    m_ph[0] = 0; m_ph[1] = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    checks += 4;
    if (q_a !== 4'b0000 || ph_a !== 3'd0) begin
      errors++; $display("FAIL %s_a got q=%b ph=%0d want q=0000 ph=0", tag, q_a, ph_a);
    end
    if (wrap_a !== 1'b0) begin
      errors++; $display("FAIL %s_wrap got %b want 0", tag, wrap_a);
    end
    if (q_b !== 5'b00001 || ph_b !== 4'd0) begin
      errors++; $display("FAIL %s_b got q=%b ph=%0d want q=00001 ph=0", tag, q_b, ph_b);
    end
`ifdef SHIFT_CNT_SELF_CORRECT_EN
    if (err_a !== 1'b0 || err_b !== 1'b0) begin
      errors++; $display("FAIL %s_err got %b%b want 00", tag, err_a, err_b);
    end
`else
    if (wrap_b !== 1'b0) begin
      errors++; $display("FAIL %s_wrap_b got %b want 0", tag, wrap_b);
    end
`endif
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1 chk_reset_state("reset_async");
    repeat (2) @(posedge clk);
    #1 chk_reset_state("reset_held");
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 chk_reset_state("reset_release_idle");
  endtask

  task automatic test_johnson_fwd();
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 0, 0);
  endtask

  task automatic test_hold();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
  endtask

  task automatic test_johnson_rev();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    #2 reset = 1'b0;
    #1 chk_reset_state("reset_mid");
    @(negedge clk) reset = 1'b1;
    m_ph[0] = 0; m_ph[1] = 0;
    cyc(0, 1, 0, 0, 0);
  endtask

  task automatic test_load();
    cyc(0, 1, 0, 1, 32'b1100);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 32'b1000);
    cyc(0, 1, 0, 1, 32'b0000);
    cyc(0, 0, 0, 1, 32'b0111);
    cyc(0, 1, 1, 0, 0);
  endtask

  task automatic test_ring();
    cyc(1, 1, 0, 1, 32'b00100);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic test_illegal_load();
    en_a = 0; dir_a = 0; load_a = 1; lv_a = 4'b0101;
    @(posedge clk);
    #1;
    load_a = 0; en_a = 1;
    checks++;
    if (q_a !== 4'b0101) begin
      errors++; $display("FAIL illegal_load got %b want 0101", q_a);
    end
    @(posedge clk);
    #1;
    en_a = 0;
`ifdef SHIFT_CNT_SELF_CORRECT_EN
    checks += 2;
    if (q_a !== 4'b0000 || ph_a !== 3'd0 || wrap_a !== 1'b0) begin
      errors++; $display("FAIL self_correct got q=%b ph=%0d wrap=%b want 0000 0 0", q_a, ph_a, wrap_a);
    end
    if (err_a !== 1'b1) begin
      errors++; $display("FAIL err_pulse got %b want 1", err_a);
    end
    m_ph[0] = 0;
    cyc(0, 1, 0, 0, 0);
    checks++;
    if (err_a !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b want 0", err_a);
    end
`else
    checks++;
    if (q_a !== 4'b1011) begin
      errors++; $display("FAIL illegal_propagate got %b want 1011", q_a);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_johnson_fwd();
    test_hold();
    test_johnson_rev();
    test_async_reset();
    test_load();
    test_ring();
    test_illegal_load();
    cyc(0, 1, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
